// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: bounded in-order requests, response queue to decode, redirect/fault handling.
// Optional same-cycle response bypass to decode when FETCH_CTRL_BYPASS_EN is defined.
module fetch_ctrl #(
    parameter int unsigned FQ_DEPTH        = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [47:0] pc_in_i,
    output logic        pc_adv_o,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [47:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic [31:0] dec_instr_o,
    output logic [47:0] dec_pc_o,
    output logic        dec_fault_o
);

    localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW  = $clog2(FQ_DEPTH + 1);
    localparam int unsigned SW  = $clog2(FQ_DEPTH + MAX_OUTSTANDING + 1);
    localparam int unsigned QAW = $clog2(FQ_DEPTH);
    localparam int unsigned PAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [OW-1:0]  MaxOut   = OW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0]  FqDepth  = CW'(FQ_DEPTH);
    localparam logic [SW-1:0]  FqDepthS = SW'(FQ_DEPTH);
    localparam logic [PAW-1:0] PcfLast  = PAW'(MAX_OUTSTANDING - 1);

    localparam logic [1:0] StFetch = 2'd0;
    localparam logic [1:0] StDrain = 2'd1;
    localparam logic [1:0] StHalt  = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [OW-1:0]  outst_q, outst_d;
    logic [OW-1:0]  kill_q, kill_d;
    logic [CW-1:0]  fq_cnt_q, fq_cnt_d;
    logic [QAW-1:0] fq_wr_q, fq_rd_q;
    logic [PAW-1:0] pcf_wr_q, pcf_rd_q;

    logic [47:0] pcf_q [MAX_OUTSTANDING];
    // Entry layout: {fault, pc, instr}
    logic [80:0] fq_q [FQ_DEPTH];

    logic        misaligned, credit, grant, rsp_live, mis_fault;
    logic        push_any, fq_push, fq_pop, head_valid;
    logic [80:0] push_entry, head_entry;

    assign misaligned  = pc_in_i[1:0] != 2'b00;
    assign credit      = (outst_q < MaxOut) && ((SW'(outst_q) + SW'(fq_cnt_q)) < FqDepthS);
    assign imem_req_o  = n_reset && (state_q == StFetch) && !flush_i && credit &&
                         (kill_q == '0) && !misaligned;
    assign imem_addr_o = pc_in_i;
    assign grant       = imem_req_o && imem_gnt_i;
    assign pc_adv_o    = grant;

    assign rsp_live  = imem_rvalid_i && (kill_q == '0) && !flush_i;
    assign mis_fault = (state_q == StFetch) && !flush_i && misaligned && (outst_q == '0) &&
                       (fq_cnt_q != FqDepth);
    assign push_any  = rsp_live || mis_fault;

    always_comb begin
        push_entry = '0;
        if (rsp_live) begin
            push_entry = {imem_err_i, pcf_q[pcf_rd_q], imem_err_i ? 32'h0 : imem_rdata_i};
        end else if (mis_fault) begin
            push_entry = {1'b1, pc_in_i, 32'h0};
        end
    end

    assign head_valid = fq_cnt_q != '0;
    assign head_entry = fq_q[fq_rd_q];
    assign fq_pop     = head_valid && dec_ready_i && !flush_i;

`ifdef FETCH_CTRL_BYPASS_EN
    logic byp;
    assign byp         = n_reset && rsp_live && !head_valid;
    assign fq_push     = push_any && !(byp && dec_ready_i);
    assign dec_valid_o = head_valid || byp;
    assign dec_fault_o = head_valid ? head_entry[80]    : push_entry[80];
    assign dec_pc_o    = head_valid ? head_entry[79:32] : push_entry[79:32];
    assign dec_instr_o = head_valid ? head_entry[31:0]  : push_entry[31:0];
`else
    assign fq_push     = push_any;
    assign dec_valid_o = head_valid;
    assign dec_fault_o = head_entry[80];
    assign dec_pc_o    = head_entry[79:32];
    assign dec_instr_o = head_entry[31:0];
`endif

    assign outst_d  = outst_q + OW'(grant) - OW'(imem_rvalid_i);
    assign fq_cnt_d = flush_i ? '0 : fq_cnt_q + CW'(fq_push) - CW'(fq_pop);

    // Every transaction still in flight after a redirect or bus error is killed.
    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        if (flush_i) begin
            kill_d  = outst_d;
            state_d = (outst_d != '0) ? StDrain : StFetch;
        end else begin
            if (imem_rvalid_i && (kill_q != '0)) begin
                kill_d = kill_q - OW'(1);
            end
            case (state_q)
                StFetch: begin
                    if (rsp_live && imem_err_i) begin
                        kill_d  = outst_d;
                        state_d = StHalt;
                    end else if (mis_fault) begin
                        state_d = StHalt;
                    end
                end
                StDrain: begin
                    if (kill_d == '0) begin
                        state_d = StFetch;
                    end
                end
                StHalt:  state_d = StHalt;
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= StFetch;
            outst_q  <= '0;
            kill_q   <= '0;
            fq_cnt_q <= '0;
            fq_wr_q  <= '0;
            fq_rd_q  <= '0;
            pcf_wr_q <= '0;
            pcf_rd_q <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) pcf_q[i] <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) fq_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            outst_q  <= outst_d;
            kill_q   <= kill_d;
            fq_cnt_q <= fq_cnt_d;
            if (grant) begin
                pcf_q[pcf_wr_q] <= pc_in_i;
                pcf_wr_q        <= (pcf_wr_q == PcfLast) ? '0 : pcf_wr_q + PAW'(1);
            end
            if (imem_rvalid_i) begin
                pcf_rd_q <= (pcf_rd_q == PcfLast) ? '0 : pcf_rd_q + PAW'(1);
            end
            if (flush_i) begin
                fq_wr_q <= '0;
                fq_rd_q <= '0;
            end else begin
                if (fq_push) begin
                    fq_q[fq_wr_q] <= push_entry;
                    fq_wr_q       <= fq_wr_q + QAW'(1);
                end
                if (fq_pop) begin
                    fq_rd_q <= fq_rd_q + QAW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle vector table plus a mid-transaction reset sequence.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [47:0] pc_in;
    logic        pc_adv, flush, imem_req, imem_gnt, imem_rvalid, imem_err;
    logic [47:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dec_valid, dec_ready, dec_fault;
    logic [31:0] dec_instr;
    logic [47:0] dec_pc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.FQ_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .pc_in_i      (pc_in),
        .pc_adv_o     (pc_adv),
        .flush_i      (flush),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_gnt_i   (imem_gnt),
        .imem_rvalid_i(imem_rvalid),
        .imem_rdata_i (imem_rdata),
        .imem_err_i   (imem_err),
        .dec_valid_o  (dec_valid),
        .dec_ready_i  (dec_ready),
        .dec_instr_o  (dec_instr),
        .dec_pc_o     (dec_pc),
        .dec_fault_o  (dec_fault)
    );

    typedef struct {
        logic [47:0] pc;
        logic        fl, gnt, rv;
        logic [31:0] rdata;
        logic        err, rdy;
        logic        e_req, e_vld;
        logic [31:0] e_instr;
        logic [47:0] e_pc;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [47:0] pc, input logic fl, input logic gnt,
                                input logic rv, input logic [31:0] rdata, input logic err,
                                input logic rdy, input logic e_req, input logic e_vld,
                                input logic [31:0] e_instr, input logic [47:0] e_pc,
                                input logic e_fault);
        vec_t v;
        v.pc = pc; v.fl = fl; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.err = err;
        v.rdy = rdy; v.e_req = e_req; v.e_vld = e_vld; v.e_instr = e_instr;
        v.e_pc = e_pc; v.e_fault = e_fault;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // Streaming with one-cycle response latency
        add(48'h1000, 0, 1, 0, 32'h0,         0, 1, 1, 0, 32'h0,         48'h0,    0);
        add(48'h1004, 0, 1, 1, 32'h0000_0013, 0, 1, 1, 0, 32'h0,         48'h0,    0);
        add(48'h1008, 0, 1, 1, 32'h0010_0093, 0, 1, 1, 1, 32'h0000_0013, 48'h1000, 0);
        add(48'h100C, 0, 0, 1, 32'h0020_0113, 0, 1, 1, 1, 32'h0010_0093, 48'h1004, 0);
        add(48'h100C, 0, 0, 0, 32'h0,         0, 1, 1, 1, 32'h0020_0113, 48'h1008, 0);
        add(48'h100C, 0, 0, 0, 32'h0,         0, 1, 1, 0, 32'h0,         48'h0,    0);
        // Backpressure: four grants fill the queue, issue resumes after the first pop
        add(48'h100C, 0, 1, 0, 32'h0,         0, 0, 1, 0, 32'h0,         48'h0,    0);
        add(48'h1010, 0, 1, 1, 32'hD000_0000, 0, 0, 1, 0, 32'h0,         48'h0,    0);
        add(48'h1014, 0, 1, 1, 32'hD000_0001, 0, 0, 1, 1, 32'hD000_0000, 48'h100C, 0);
        add(48'h1018, 0, 1, 1, 32'hD000_0002, 0, 0, 1, 1, 32'hD000_0000, 48'h100C, 0);
        add(48'h101C, 0, 1, 1, 32'hD000_0003, 0, 0, 0, 1, 32'hD000_0000, 48'h100C, 0);
        add(48'h101C, 0, 1, 0, 32'h0,         0, 0, 0, 1, 32'hD000_0000, 48'h100C, 0);
        add(48'h101C, 0, 0, 0, 32'h0,         0, 1, 0, 1, 32'hD000_0000, 48'h100C, 0);
        add(48'h101C, 0, 0, 0, 32'h0,         0, 1, 1, 1, 32'hD000_0001, 48'h1010, 0);
        add(48'h101C, 0, 0, 0, 32'h0,         0, 1, 1, 1, 32'hD000_0002, 48'h1014, 0);
        add(48'h101C, 0, 0, 0, 32'h0,         0, 1, 1, 1, 32'hD000_0003, 48'h1018, 0);
        add(48'h101C, 0, 0, 0, 32'h0,         0, 1, 1, 0, 32'h0,         48'h0,    0);
        // Flush with two outstanding: both responses dropped, no request while draining
        add(48'h101C, 0, 1, 0, 32'h0,         0, 1, 1, 0, 32'h0,         48'h0,    0);
        add(48'h1020, 0, 1, 0, 32'h0,         0, 1, 1, 0, 32'h0,         48'h0,    0);
        add(48'h2000, 1, 1, 0, 32'h0,         0, 1, 0, 0, 32'h0,         48'h0,    0);
        add(48'h2000, 0, 1, 1, 32'hDEAD_DEAD, 0, 1, 0, 0, 32'h0,         48'h0,    0);
        add(48'h2000, 0, 1, 1, 32'hBEEF_BEEF, 0, 1, 0, 0, 32'h0,         48'h0,    0);
        add(48'h2000, 0, 1, 0, 32'h0,         0, 1, 1, 0, 32'h0,         48'h0,    0);
        add(48'h2004, 0, 0, 1, 32'hE000_0000, 0, 1, 1, 0, 32'h0,         48'h0,    0);
        add(48'h2004, 0, 0, 0, 32'h0,         0, 1, 1, 1, 32'hE000_0000, 48'h2000, 0);
        add(48'h2004, 0, 0, 0, 32'h0,         0, 1, 1, 0, 32'h0,         48'h0,    0);
        // Misaligned PC: fault entry, halted until flush
        add(48'h1002, 0, 1, 0, 32'h0,         0, 0, 0, 0, 32'h0,         48'h0,    0);
        add(48'h1002, 0, 1, 0, 32'h0,         0, 0, 0, 1, 32'h0,         48'h1002, 1);
        add(48'h1004, 0, 1, 0, 32'h0,         0, 1, 0, 1, 32'h0,         48'h1002, 1);
        add(48'h1004, 0, 1, 0, 32'h0,         0, 1, 0, 0, 32'h0,         48'h0,    0);
        add(48'h3000, 1, 1, 0, 32'h0,         0, 1, 0, 0, 32'h0,         48'h0,    0);
        add(48'h3000, 0, 0, 0, 32'h0,         0, 1, 1, 0, 32'h0,         48'h0,    0);
        // Bus error on second response with a third request in flight
        add(48'h3000, 0, 1, 0, 32'h0,         0, 1, 1, 0, 32'h0,         48'h0,    0);
        add(48'h3004, 0, 1, 1, 32'hF000_0000, 0, 1, 1, 0, 32'h0,         48'h0,    0);
        add(48'h3008, 0, 1, 1, 32'hFFFF_FFFF, 1, 1, 1, 1, 32'hF000_0000, 48'h3000, 0);
        add(48'h300C, 0, 1, 1, 32'h0000_0055, 0, 1, 0, 1, 32'h0,         48'h3004, 1);
        add(48'h300C, 0, 1, 0, 32'h0,         0, 1, 0, 0, 32'h0,         48'h0,    0);
        add(48'h4000, 1, 0, 0, 32'h0,         0, 1, 0, 0, 32'h0,         48'h0,    0);
        // Flush together with gnt and a live response: request suppressed, response dropped
        add(48'h4000, 0, 1, 0, 32'h0,         0, 1, 1, 0, 32'h0,         48'h0,    0);
        add(48'h4004, 0, 1, 0, 32'h0,         0, 1, 1, 0, 32'h0,         48'h0,    0);
        add(48'h5000, 1, 1, 1, 32'h6000_0000, 0, 1, 0, 0, 32'h0,         48'h0,    0);
        add(48'h5000, 0, 1, 0, 32'h0,         0, 1, 0, 0, 32'h0,         48'h0,    0);
        add(48'h5000, 0, 1, 1, 32'h0BAD_0BAD, 0, 1, 0, 0, 32'h0,         48'h0,    0);
        add(48'h5000, 0, 0, 0, 32'h0,         0, 1, 1, 0, 32'h0,         48'h0,    0);
        // Flush clears a non-empty queue
        add(48'h5000, 0, 1, 0, 32'h0,         0, 0, 1, 0, 32'h0,         48'h0,    0);
        add(48'h5004, 0, 0, 1, 32'h7000_0000, 0, 0, 1, 0, 32'h0,         48'h0,    0);
        add(48'h6000, 1, 0, 0, 32'h0,         0, 0, 0, 1, 32'h7000_0000, 48'h5000, 0);
        add(48'h6000, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h0,         48'h0,    0);

        // Reset state, with inputs that would otherwise request
        n_reset = 1'b0; pc_in = 48'h1000; flush = 1'b0; imem_gnt = 1'b1;
        imem_rvalid = 1'b0; imem_rdata = '0; imem_err = 1'b0; dec_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.req", 64'(imem_req), 64'h0);
        check("rst.adv", 64'(pc_adv), 64'h0);
        check("rst.valid", 64'(dec_valid), 64'h0);
        check("rst.instr", 64'(dec_instr), 64'h0);
        check("rst.pc", 64'(dec_pc), 64'h0);
        check("rst.fault", 64'(dec_fault), 64'h0);
        @(posedge clk); #1;
        n_reset = 1'b1;

        foreach (vecs[i]) begin
            pc_in = vecs[i].pc; flush = vecs[i].fl; imem_gnt = vecs[i].gnt;
            imem_rvalid = vecs[i].rv; imem_rdata = vecs[i].rdata; imem_err = vecs[i].err;
            dec_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("v%0d.req", i), 64'(imem_req), 64'(vecs[i].e_req));
            check($sformatf("v%0d.adv", i), 64'(pc_adv), 64'(vecs[i].e_req & vecs[i].gnt));
            check($sformatf("v%0d.addr", i), 64'(imem_addr), 64'(vecs[i].pc));
            check($sformatf("v%0d.valid", i), 64'(dec_valid), 64'(vecs[i].e_vld));
            if (vecs[i].e_vld) begin
                check($sformatf("v%0d.instr", i), 64'(dec_instr), 64'(vecs[i].e_instr));
                check($sformatf("v%0d.pc", i), 64'(dec_pc), 64'(vecs[i].e_pc));
                check($sformatf("v%0d.fault", i), 64'(dec_fault), 64'(vecs[i].e_fault));
            end
            @(posedge clk); #1;
        end

        // Reset in the middle of a transaction clears queue and outstanding count
        pc_in = 48'h7000; flush = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; dec_ready = 1'b0;
        @(negedge clk);
        check("mr.req0", 64'(imem_req), 64'h1);
        @(posedge clk); #1;
        pc_in = 48'h7004; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0000;
        @(negedge clk);
        check("mr.valid0", 64'(dec_valid), 64'h0);
        @(posedge clk); #1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        check("mr.valid1", 64'(dec_valid), 64'h1);
        n_reset = 1'b0;
        #1;
        check("mr.req_in_rst", 64'(imem_req), 64'h0);
        check("mr.valid_in_rst", 64'(dec_valid), 64'h0);
        check("mr.pc_in_rst", 64'(dec_pc), 64'h0);
        check("mr.instr_in_rst", 64'(dec_instr), 64'h0);
        @(posedge clk); #1;
        n_reset = 1'b1; imem_gnt = 1'b1;
        @(negedge clk);
        check("mr.req1", 64'(imem_req), 64'h1);
        check("mr.valid2", 64'(dec_valid), 64'h0);
        @(posedge clk); #1;
        pc_in = 48'h7008;
        @(negedge clk);
        check("mr.req2", 64'(imem_req), 64'h1);
        @(posedge clk); #1;
        pc_in = 48'h700C;
        @(negedge clk);
        check("mr.req_cap", 64'(imem_req), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
